door_keypad_encoder: RTL and testbench
======================================

# door_keypad_encoder

Front-end producer of the 4-bit `btn` code stream consumed by `Door_System`. It synchronizes and debounces four raw keypad lines, then emits each settled, non-zero key pattern as a clean code for a fixed number of cycles. Between codes the output is zero. It then waits for full key release before it accepts the next press. It sits between the physical keypad pins and the lock FSM's `btn` input, on the lock's clock.

## Interface
- `DEBOUNCE`, 4: consecutive synchronized cycles a pattern must hold to count as stable (1..255).
- `PULSE_LEN`, 10: cycles each emitted code is held on `btn` (1..255). The default of 10 matches one step of the lock's button sequence.
- `REPEAT`, 50: hold cycles between auto-repeat emissions. Used only with `DOOR_KEYPAD_REPEAT_EN`.
- `clk` in 1: the only clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `keys` in 4: raw, asynchronous, active-high key lines. Bounce is allowed.
- `btn` out 4: emitted key code. It is 0 when no code is being emitted. Connects to `Door_System` `btn`.
- `btn_valid` out 1: high exactly while `btn` is non-zero.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Two-flop synchronizer on `keys` produces `ks`. A stability counter (8 bits, saturating) clears whenever `ks` differs from its value on the previous cycle. Otherwise it increments. "Stable" means counter ≥ DEBOUNCE.
- **IDLE**:
  - `btn`=0.
  - If `ks` is non-zero and stable, latch `code`←`ks` and go to EMIT.
  - `ks`=0 keeps the block in IDLE.
- **EMIT**:
  - `btn`=`code` and `btn_valid`=1 for exactly PULSE_LEN cycles.
  - Changes on `keys` do not alter the latched `code`.
  - At the end of the pulse, go to RELEASE.
- **RELEASE**:
  - `btn`=0.
  - When `ks`=0 and stable, go to IDLE.
  - A different non-zero pattern (rollover) is never emitted here. Keys must return to all-zero first.
- Chords are emitted as their raw OR pattern. For example, keys 0 and 1 held together emit 3. No priority encoding is applied.
- Reset values: `btn`=0, `btn_valid`=0, `busy`=0, state=IDLE, synchronizer=0, counter=0, `code`=0.
- Reset mid-EMIT: `btn` drops to 0 asynchronously. After reset deasserts, a key that is still held is treated as a new press and is re-emitted after the full debounce.
- Counters never wrap. The PULSE_LEN and REPEAT counters reload on each state entry.

## Timing
- Edge 0 is the first rising edge that samples a new, steady `keys` value.
  - `ks` updates at edge 1.
  - The counter reaches DEBOUNCE at edge DEBOUNCE+1.
  - The FSM enters EMIT at edge DEBOUNCE+2, so `btn`/`btn_valid` are valid from edge DEBOUNCE+2 through edge DEBOUNCE+1+PULSE_LEN.
- Any `ks` change before the counter reaches DEBOUNCE restarts the count, which pushes emission out accordingly.
- Minimum zero gap between two codes is DEBOUNCE+2 cycles after release.
- `btn` and `btn_valid` are registered outputs. They are never combinational from `keys`.

## Configuration
- **`DOOR_KEYPAD_REPEAT_EN` defined**: in RELEASE, if `ks` equals `code` continuously for REPEAT cycles, re-enter EMIT with the same `code`. The repeat count restarts on every re-entry to RELEASE and on any `ks` change.
- **Not defined**: holding a key produces exactly one emission regardless of duration. The REPEAT parameter is ignored and its counter is not synthesized.

## Test plan
- Clean press of `keys`=1 with DEBOUNCE=4 and PULSE_LEN=10: `btn`=1 and `btn_valid`=1 from edge 6 through edge 15 after the press, then 0. `busy` returns to 0 after release plus 6 cycles.
- Bounce: `keys` toggles 1/0 every cycle for 3 cycles, then holds 1. Exactly one emission of 1, with timing referenced to the last transition.
- Sequence 1, 3 (chord of keys 0+1), 2, 4, each held 30 cycles with 30-cycle gaps: `btn` shows pulses 1, 3, 2, 4 in order, each 10 cycles long. A connected `Door_System` asserts `green`.
- Rollover: hold 1, then press 2 while 1 is still held, then release both. Only code 1 is emitted. Without `DOOR_KEYPAD_REPEAT_EN`, a 200-cycle hold of 1 gives one emission.
- Reset asserted during cycle 3 of EMIT: `btn`=0 immediately. With `keys`=4 still held after deassert, `btn`=4 re-emits at edge DEBOUNCE+2 after the first post-reset sampling edge.
- With `DOOR_KEYPAD_REPEAT_EN` and REPEAT=50, hold 2 for 200 cycles: emissions of 2 start at edge 6, then every 60 cycles (PULSE_LEN+REPEAT). None after release.

Source files
------------

// File: rtl/door_keypad_if.sv
// door_keypad_if: bundles the keypad encoder's key inputs and code outputs.
//   keys      : raw asynchronous active-high key lines (master -> slave)
//   btn       : emitted 4-bit key code, 0 between codes (slave -> master)
//   btn_valid : high exactly while btn is non-zero (slave -> master)
//   busy      : high whenever the encoder is not idle (slave -> master)
interface door_keypad_if;
  logic [3:0] keys;
  logic [3:0] btn;
  logic       btn_valid;
  logic       busy;

  modport master (output keys, input btn, input btn_valid, input busy);
  modport slave  (input keys, output btn, output btn_valid, output busy);
endinterface

// File: rtl/door_keypad_encoder.sv
// door_keypad_encoder: synchronizes and debounces four raw keypad lines and
// emits each settled non-zero pattern as a fixed-length code on btn, then
// waits for full key release before accepting the next press.
//   clk   : only clock, rising edge
//   reset : asynchronous active-high reset
//   kp    : door_keypad_if.slave (keys in; btn, btn_valid, busy out)
// Parameters: DEBOUNCE (stable cycles), PULSE_LEN (code hold cycles),
//   REPEAT (auto-repeat hold cycles, only with DOOR_KEYPAD_REPEAT_EN).
// Optional feature macro: DOOR_KEYPAD_REPEAT_EN enables auto-repeat of a
//   held key from RELEASE; without it a hold yields a single emission.
module door_keypad_encoder #(
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned PULSE_LEN = 10,
  parameter int unsigned REPEAT    = 50
) (
  input logic          clk,
  input logic          reset,
  door_keypad_if.slave kp
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EMIT    = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e        state_q;
  logic [3:0]    sync1_q;
  logic [3:0]    ks_q;
  logic [3:0]    code_q;
  logic [3:0]    btn_q;
  logic          btn_valid_q;
  logic          busy_q;
  logic [CW-1:0] stab_q;
  logic [CW-1:0] stab_d;
  logic [CW-1:0] pulse_q;
  logic          stable_c;

`ifdef DOOR_KEYPAD_REPEAT_EN
  logic [CW-1:0] rep_q;
`else
  logic unused_repeat;
  assign unused_repeat = ^CW'(REPEAT);
`endif

  // Saturating stability counter: restarts whenever the synchronized value moves.
  always_comb begin
    stab_d = stab_q;
    if (sync1_q != ks_q) begin
      stab_d = '0;
    end else if (stab_q != '1) begin
      stab_d = stab_q + CW'(1);
    end
  end

  assign stable_c = (stab_q >= CW'(DEBOUNCE));

  // Synchronizer, debounce counter and emit/release FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= '0;
      ks_q        <= '0;
      stab_q      <= '0;
      code_q      <= '0;
      pulse_q     <= '0;
      btn_q       <= '0;
      btn_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DOOR_KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      sync1_q <= kp.keys;
      ks_q    <= sync1_q;
      stab_q  <= stab_d;
      case (state_q)
        S_IDLE: begin
          if ((ks_q != 4'd0) && stable_c) begin
            state_q     <= S_EMIT;
            code_q      <= ks_q;
            btn_q       <= ks_q;
            btn_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            pulse_q     <= CW'(PULSE_LEN - 1);
          end
        end
        S_EMIT: begin
          // Latched code is held regardless of key activity.
          if (pulse_q == '0) begin
            state_q     <= S_RELEASE;
            btn_q       <= '0;
            btn_valid_q <= 1'b0;
`ifdef DOOR_KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
          end else begin
            pulse_q <= pulse_q - CW'(1);
            btn_q   <= code_q;
          end
        end
        S_RELEASE: begin
          // Only a stable all-zero pattern re-arms; rollover patterns are ignored.
          if ((ks_q == 4'd0) && stable_c) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
`ifdef DOOR_KEYPAD_REPEAT_EN
          else if (ks_q == code_q) begin
            if (rep_q == CW'(REPEAT - 1)) begin
              state_q     <= S_EMIT;
              btn_q       <= code_q;
              btn_valid_q <= 1'b1;
              pulse_q     <= CW'(PULSE_LEN - 1);
            end else begin
              rep_q <= rep_q + CW'(1);
            end
          end else begin
            rep_q <= '0;
          end
`endif
        end
        default: begin
          state_q     <= S_IDLE;
          btn_q       <= '0;
          btn_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign kp.btn       = btn_q;
  assign kp.btn_valid = btn_valid_q;
  assign kp.busy      = busy_q;

endmodule

// File: tb/tb_door_keypad_encoder.sv
// tb_door_keypad_encoder: table-driven press scenarios, hand-written corner
// sequences and random key traffic, all checked cycle by cycle against a
// key-history reference model.
module tb_door_keypad_encoder;

  localparam int unsigned D = 4;
  localparam int unsigned P = 10;
  localparam int unsigned R = 50;

  localparam int M_WAIT = 0;
  localparam int M_OUT  = 1;
  localparam int M_HOLD = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  door_keypad_if kp();

  door_keypad_encoder #(.DEBOUNCE(D), .PULSE_LEN(P), .REPEAT(R)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: raw key history since reset plus emission bookkeeping.
  logic [3:0] hist[$];
  int         m_mode;
  int         m_left;
  int         m_anchor;
  logic [3:0] m_code;

  // Per-scenario measurements.
  int         meas_edge;
  int         n_emit;
  int         first_edge;
  int         first_len;
  int         first_code;
  logic [3:0] prev_btn;

  typedef struct {
    logic [3:0] keys;
    int         bounce;
    int         hold;
    int         exp_n;
    int         exp_first;
    int         exp_code;
    int         exp_len;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] hk(input int idx);
    if (idx < 0) return 4'd0;
    return hist[idx];
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_mode   = M_WAIT;
    m_left   = 0;
    m_anchor = 0;
    m_code   = 4'd0;
  endfunction

  // Keys seen at edge e reach the FSM decision at edge e+2; stable means the
  // last D+1 such samples are identical.
  function automatic void model_step(input logic [3:0] k);
    int         e;
    logic [3:0] v;
    bit         stable;
    hist.push_back(k);
    e      = hist.size() - 1;
    v      = hk(e - 2);
    stable = 1'b1;
    for (int j = 1; j <= int'(D); j++) begin
      if (hk(e - 2 - j) != v) stable = 1'b0;
    end
    case (m_mode)
      M_WAIT: begin
        if (stable && v != 4'd0) begin
          m_mode = M_OUT;
          m_code = v;
          m_left = int'(P);
        end
      end
      M_OUT: begin
        m_left--;
        if (m_left == 0) begin
          m_mode   = M_HOLD;
          m_anchor = e;
        end
      end
      default: begin
        if (stable && v == 4'd0) begin
          m_mode = M_WAIT;
        end
`ifdef DOOR_KEYPAD_REPEAT_EN
        else if (v != m_code) begin
          m_anchor = e;
        end else if (e - m_anchor >= int'(R)) begin
          m_mode = M_OUT;
          m_left = int'(P);
        end
`endif
      end
    endcase
  endfunction

  task automatic meas_clear();
    meas_edge  = 0;
    n_emit     = 0;
    first_edge = -1;
    first_len  = 0;
    first_code = 0;
    prev_btn   = kp.btn;
  endtask

  // One clock: apply keys, advance the model at the edge, compare just after it.
  task automatic cycle(input logic [3:0] k);
    int exp_btn;
    kp.keys = k;
    @(posedge clk);
    model_step(k);
    #1;
    exp_btn = (m_mode == M_OUT) ? int'(m_code) : 0;
    chk("btn", int'(kp.btn), exp_btn);
    chk("btn_valid", int'(kp.btn_valid), (m_mode == M_OUT) ? 1 : 0);
    chk("busy", int'(kp.busy), (m_mode != M_WAIT) ? 1 : 0);
    if (kp.btn != 4'd0 && prev_btn == 4'd0) begin
      n_emit++;
      if (n_emit == 1) begin
        first_edge = meas_edge;
        first_code = int'(kp.btn);
      end
    end
    if (kp.btn != 4'd0 && n_emit == 1) first_len++;
    prev_btn = kp.btn;
    meas_edge++;
  endtask

  task automatic drive(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) cycle(k);
  endtask

  initial begin
    int idle_at;
    logic [3:0] rv;

    tbl[0] = '{4'h1, 0, 30, 1, 6, 1, 10};
    tbl[1] = '{4'h3, 0, 30, 1, 6, 3, 10};
    tbl[2] = '{4'h2, 0, 30, 1, 6, 2, 10};
    tbl[3] = '{4'h4, 0, 30, 1, 6, 4, 10};
    tbl[4] = '{4'hF, 0, 25, 1, 6, 15, 10};
    tbl[5] = '{4'h8, 0, 5, 1, 6, 8, 10};
    tbl[6] = '{4'h8, 0, 4, 0, -1, 0, 0};
    tbl[7] = '{4'h1, 4, 26, 1, 10, 1, 10};
    tbl[8] = '{4'h6, 3, 26, 1, 8, 6, 10};

    reset   = 1'b1;
    kp.keys = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_btn", int'(kp.btn), 0);
    chk("reset_valid", int'(kp.btn_valid), 0);
    chk("reset_busy", int'(kp.busy), 0);
    reset = 1'b0;
    drive(4'd0, 10);

    // Table of single presses: optional bounce prefix, hold, then release.
    for (int t = 0; t < 9; t++) begin
      meas_clear();
      for (int b = 0; b < tbl[t].bounce; b++) cycle((b % 2 == 0) ? tbl[t].keys : 4'd0);
      drive(tbl[t].keys, tbl[t].hold);
      drive(4'd0, 40);
      chk($sformatf("vec%0d_count", t), n_emit, tbl[t].exp_n);
      chk($sformatf("vec%0d_first", t), first_edge, tbl[t].exp_first);
      chk($sformatf("vec%0d_code", t), first_code, tbl[t].exp_code);
      chk($sformatf("vec%0d_len", t), first_len, tbl[t].exp_len);
    end

    // Release-to-idle latency after a long hold.
    drive(4'h1, 30);
    idle_at = -1;
    for (int i = 0; i < 40; i++) begin
      cycle(4'd0);
      if (kp.busy == 1'b0 && idle_at < 0) idle_at = i;
    end
    chk("release_idle_latency", idle_at, 6);

    // Rollover: second key while first held is never emitted.
    meas_clear();
    drive(4'h1, 20);
    drive(4'h3, 20);
    drive(4'd0, 40);
    chk("rollover_count", n_emit, 1);
    chk("rollover_code", first_code, 1);

    // Long hold: single emission, or one every P+R cycles with auto-repeat.
    meas_clear();
    drive(4'h2, 200);
    drive(4'd0, 40);
    chk("long_first", first_edge, 6);
`ifdef DOOR_KEYPAD_REPEAT_EN
    chk("long_count", n_emit, 4);
`else
    chk("long_count", n_emit, 1);
`endif

    // Reset during the third EMIT cycle, key still held afterwards.
    meas_clear();
    drive(4'h4, 9);
    chk("pre_reset_btn", int'(kp.btn), 4);
    reset = 1'b1;
    #2;
    chk("async_reset_btn", int'(kp.btn), 0);
    chk("async_reset_valid", int'(kp.btn_valid), 0);
    chk("async_reset_busy", int'(kp.busy), 0);
    model_reset();
    #2;
    reset = 1'b0;
    meas_clear();
    drive(4'h4, 30);
    drive(4'd0, 40);
    chk("post_reset_first", first_edge, 6);
    chk("post_reset_code", first_code, 4);
    chk("post_reset_count", n_emit, 1);

    // Random key traffic including short glitches and chords.
    for (int s = 0; s < 80; s++) begin
      rv = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      drive(rv, int'($urandom_range(1, 35)));
    end
    drive(4'd0, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
